// File: rtl/addr_load_shift_out.sv
// rtl/addr_load_shift_out.sv - random-access fill buffer drained from slot 0 by shifting
// Words are written by slot address in FILL, then streamed out through Q with valid/ready in DRAIN.
module addr_load_shift_out #(
  parameter int C_WIDTH      = 16,
  parameter int C_DEPTH      = 16,
  parameter int C_ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    ACLR_N,
  input  logic                    SCLR,
  input  logic                    WE,
  input  logic [C_ADDR_WIDTH-1:0] WA,
  input  logic [C_WIDTH-1:0]      WD,
  input  logic                    START,
  input  logic [C_ADDR_WIDTH:0]   LEN,
  output logic [C_WIDTH-1:0]      Q,
  output logic                    Q_VALID,
  input  logic                    Q_READY,
  output logic                    BUSY,
  output logic                    ERR
);

  localparam int LP_CW = C_ADDR_WIDTH + 1;
  localparam int LP_IW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
  localparam logic [LP_CW-1:0] LP_DEPTH = LP_CW'(C_DEPTH);
  localparam logic [LP_CW-1:0] LP_ONE   = LP_CW'(1);

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [LP_CW-1:0]   r_count;
  logic [LP_CW-1:0]   w_next_count;
  logic [LP_CW-1:0]   w_len_eff;
  logic [C_WIDTH-1:0] r_slots [C_DEPTH];
  logic               r_err;
  logic               w_wr_en;
  logic               w_shift;
  logic               w_set_err;
  logic               w_xfer;
  logic               w_wa_ok;
  logic [LP_IW-1:0]   w_wa_idx;

  assign w_wa_ok  = ({1'b0, WA} < LP_DEPTH);
  assign w_wa_idx = LP_IW'(WA);
  // Zero or oversize lengths drain the whole buffer.
  assign w_len_eff = ((LEN == '0) || (LEN > LP_DEPTH)) ? LP_DEPTH : LEN;

  assign BUSY    = (r_state == ST_DRAIN);
  assign Q_VALID = (r_state == ST_DRAIN) && (r_count != '0);
  assign Q       = r_slots[0];
  assign ERR     = r_err;
  assign w_xfer  = Q_VALID && Q_READY;

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      r_state <= ST_FILL;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (SCLR) begin
      r_state <= ST_FILL;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      r_err   <= r_err | w_set_err;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_wr_en      = 1'b0;
    w_shift      = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (WE) begin
          if (w_wa_ok) w_wr_en = 1'b1;
          else         w_set_err = 1'b1;
        end
        if (START) begin
          w_next_state = ST_DRAIN;
          w_next_count = w_len_eff;
        end
      end
      ST_DRAIN: begin
        if (WE || START) w_set_err = 1'b1;
        if (w_xfer) begin
          w_shift      = 1'b1;
          w_next_count = r_count - LP_ONE;
          if (r_count == LP_ONE) w_next_state = ST_FILL;
        end
      end
      default: w_next_state = ST_FILL;
    endcase
  end

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      for (int i = 0; i < C_DEPTH; i++) r_slots[i] <= '0;
    end else if (SCLR) begin
      for (int i = 0; i < C_DEPTH; i++) r_slots[i] <= '0;
    end else if (w_shift) begin
      for (int i = 0; i < C_DEPTH - 1; i++) r_slots[i] <= r_slots[i+1];
      r_slots[C_DEPTH-1] <= '0;
    end else if (w_wr_en) begin
      r_slots[w_wa_idx] <= WD;
    end
  end

endmodule

// File: tb/tb_addr_load_shift_out.sv
// tb/tb_addr_load_shift_out.sv - scoreboard bench for addr_load_shift_out
// Stimulus pushes expected words; a negedge monitor pops them on every transfer.
module tb_addr_load_shift_out;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          ACLR_N;
  logic          SCLR;
  logic          WE;
  logic [AW-1:0] WA;
  logic [W-1:0]  WD;
  logic          START;
  logic [AW:0]   LEN;
  logic [W-1:0]  Q;
  logic          Q_VALID;
  logic          Q_READY;
  logic          BUSY;
  logic          ERR;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_q = '0;

  addr_load_shift_out #(.C_WIDTH(W), .C_DEPTH(D), .C_ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .ACLR_N(ACLR_N), .SCLR(SCLR), .WE(WE), .WA(WA), .WD(WD),
    .START(START), .LEN(LEN), .Q(Q), .Q_VALID(Q_VALID), .Q_READY(Q_READY),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (prev_stall) begin
      check("stall_valid_hold", 32'(Q_VALID), 32'd1);
      check("stall_q_hold", 32'(Q), 32'(prev_q));
    end
    if (Q_VALID && Q_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=0x%0h required=none", Q);
      end else begin
        check("word", 32'(Q), 32'(exp_q.pop_front()));
      end
    end
    prev_stall = Q_VALID && !Q_READY && ACLR_N && !SCLR;
    prev_q     = Q;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    WE = 1'b1; WA = a; WD = d;
    tick();
    WE = 1'b0;
  endtask

  task automatic start(input logic [AW:0] len);
    START = 1'b1; LEN = len;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (BUSY && n < budget) begin
      tick();
      n++;
    end
    if (BUSY) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=busy required=idle");
    end
  endtask

  initial begin
    int n;
    ACLR_N = 1'b1; SCLR = 1'b0; WE = 1'b0; WA = '0; WD = '0;
    START = 1'b0; LEN = '0; Q_READY = 1'b0;
    #1 ACLR_N = 1'b0;
    #1;
    check("rst_q", 32'(Q), 32'h0);
    check("rst_q_valid", 32'(Q_VALID), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);

    // Release between edges with a write pending for the first edge.
    #10;
    ACLR_N = 1'b1; WE = 1'b1; WA = '0; WD = 16'h0055;
    tick();
    WE = 1'b0;
    check("first_edge_write", 32'(Q), 32'h0055);

    // Full drain with LEN=0.
    for (int i = 0; i < 16; i++) wr(AW'(i), W'(16'h100 + i));
    Q_READY = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(W'(16'h100 + i));
    start(6'd0);
    check("first_valid_after_start", 32'(Q_VALID), 32'd1);
    check("first_word", 32'(Q), 32'h100);
    wait_idle(40, n);
    check("full_drain_cycles", 32'(n), 32'd16);
    check("full_drain_valid_low", 32'(Q_VALID), 32'd0);
    check("full_drain_busy_low", 32'(BUSY), 32'd0);
    check("full_drain_err", 32'(ERR), 32'd0);

    // LEN=5 with alternating ready, then drain the shifted remainder.
    for (int i = 0; i < 16; i++) wr(AW'(i), W'(16'h100 + i));
    for (int i = 0; i < 5; i++) exp_q.push_back(W'(16'h100 + i));
    start(6'd5);
    n = 0;
    while (BUSY && n < 40) begin
      Q_READY = (n % 2 == 0);
      tick();
      n++;
    end
    Q_READY = 1'b1;
    check("len5_cycles", 32'(n), 32'd9);
    check("len5_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 5; i < 16; i++) exp_q.push_back(W'(16'h100 + i));
    for (int i = 0; i < 5; i++) exp_q.push_back('0);
    start(6'd0);
    wait_idle(40, n);
    check("remainder_cycles", 32'(n), 32'd16);

    // Out-of-range write, oversize LEN, then SCLR priority.
    for (int i = 0; i < 16; i++) wr(AW'(i), W'(16'h200 + i));
    wr(5'd20, 16'hDEAD);
    check("oor_err_set", 32'(ERR), 32'd1);
    tick();
    check("oor_err_sticky", 32'(ERR), 32'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(W'(16'h200 + i));
    start(6'd20);
    wait_idle(40, n);
    check("oversize_len_cycles", 32'(n), 32'd16);
    check("err_sticky_after_drain", 32'(ERR), 32'd1);
    wr(5'd0, 16'h0077);
    SCLR = 1'b1; WE = 1'b1; WA = 5'd1; WD = 16'h0099; START = 1'b1; LEN = 6'd2;
    tick();
    SCLR = 1'b0; WE = 1'b0; START = 1'b0;
    check("sclr_err", 32'(ERR), 32'd0);
    check("sclr_busy", 32'(BUSY), 32'd0);
    check("sclr_q", 32'(Q), 32'h0);
    exp_q.push_back('0);
    exp_q.push_back('0);
    start(6'd2);
    wait_idle(20, n);
    check("sclr_drain_cycles", 32'(n), 32'd2);

    // Write coinciding with START.
    WE = 1'b1; WA = '0; WD = 16'hABCD;
    exp_q.push_back(16'hABCD);
    start(6'd1);
    WE = 1'b0;
    wait_idle(20, n);
    check("we_start_cycles", 32'(n), 32'd1);
    check("we_start_err", 32'(ERR), 32'd0);

    // WE and START while draining are ignored but flagged.
    for (int i = 0; i < 4; i++) wr(AW'(i), W'(16'h300 + i));
    Q_READY = 1'b0;
    start(6'd4);
    WE = 1'b1; WA = '0; WD = 16'hEEEE;
    tick();
    WE = 1'b0;
    START = 1'b1; LEN = 6'd1;
    tick();
    START = 1'b0;
    check("drain_ops_err", 32'(ERR), 32'd1);
    check("drain_ops_q", 32'(Q), 32'h300);
    for (int i = 0; i < 4; i++) exp_q.push_back(W'(16'h300 + i));
    Q_READY = 1'b1;
    wait_idle(20, n);
    check("drain_ops_count", 32'(n), 32'd4);
    SCLR = 1'b1;
    tick();
    SCLR = 1'b0;
    check("err_cleared", 32'(ERR), 32'd0);

    // Asynchronous reset pulse mid-drain.
    for (int i = 0; i < 8; i++) wr(AW'(i), W'(16'h400 + i));
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(16'h400 + i));
    start(6'd8);
    tick();
    tick();
    #1 ACLR_N = 1'b0;
    #2;
    check("aclr_q_valid", 32'(Q_VALID), 32'd0);
    check("aclr_q", 32'(Q), 32'h0);
    check("aclr_busy", 32'(BUSY), 32'd0);
    #1 ACLR_N = 1'b1;
    check("aclr_words_sent", 32'(8 - exp_q.size()), 32'd2);
    exp_q.delete();
    tick();
    tick();
    check("aclr_no_resume", 32'(Q_VALID), 32'd0);
    wr(5'd0, 16'h5A5A);
    check("aclr_state_fill", 32'(Q), 32'h5A5A);
    check("aclr_err", 32'(ERR), 32'd0);

    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
